watch_mode_ctrl: RTL

- Top-level mode controller for the multi-function watch.
- Four shared front-panel buttons, already edge-detected to one-cycle pulses, are routed to one of three timekeeping sub-blocks: watch, stopwatch and cook timer.
- Selects which sub-block's BCD time drives the shared display.
- Owns the common 1 Hz tick and sequences the timer-expiry alarm, including pre-emption and return to the previous mode.

---
 rtl/watch_mode_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/watch_mode_ctrl.sv
// Mode controller for the multi-function watch: 1 Hz tick, button routing, display select, alarm sequencing.
// Optional idle auto-return to WATCH is enabled by defining WATCH_AUTO_RETURN_EN.
module watch_mode_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned ALARM_SEC = 10,
  parameter int unsigned IDLE_SEC  = 30
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [3:0]  btn_pedge,
  input  logic        timer_done,
  input  logic [15:0] watch_bcd,
  input  logic [15:0] stopwatch_bcd,
  input  logic [15:0] timer_bcd,
  output logic [2:0]  watch_btn,
  output logic [2:0]  stopwatch_btn,
  output logic [2:0]  timer_btn,
  output logic        sec_tick,
  output logic [15:0] disp_value,
  output logic [1:0]  mode,
  output logic [3:0]  mode_led,
  output logic        alarm
);

  typedef enum logic [1:0] {
    M_WATCH     = 2'd0,
    M_STOPWATCH = 2'd1,
    M_TIMER     = 2'd2,
    M_ALARM     = 2'd3
  } mode_t;

  localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
  localparam logic [7:0]  ALARM_LOAD = 8'(ALARM_SEC);

  mode_t       state, state_nxt;
  mode_t       saved, saved_nxt;
  logic [31:0] tick_cnt;
  logic [7:0]  alarm_cnt, alarm_cnt_nxt;
  logic        fwd_en;

`ifdef WATCH_AUTO_RETURN_EN
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_SEC - 1);
  logic [7:0] idle_cnt, idle_nxt;
`else
  logic [7:0] unused_idle_sec;
  assign unused_idle_sec = 8'(IDLE_SEC);
`endif

  // Priority: timer_done, then alarm handling, then mode press, then plain routing.
  always_comb begin
    state_nxt     = state;
    saved_nxt     = saved;
    alarm_cnt_nxt = alarm_cnt;
    fwd_en        = 1'b0;
`ifdef WATCH_AUTO_RETURN_EN
    idle_nxt      = 8'd0;
`endif
    if (timer_done) begin
      state_nxt     = M_ALARM;
      alarm_cnt_nxt = ALARM_LOAD;
      if (state != M_ALARM) saved_nxt = state;
    end else if (state == M_ALARM) begin
      if (|btn_pedge) begin
        state_nxt = saved;
      end else if (sec_tick) begin
        alarm_cnt_nxt = alarm_cnt - 8'd1;
        if (alarm_cnt <= 8'd1) state_nxt = saved;
      end
    end else if (btn_pedge[3]) begin
      case (state)
        M_WATCH:     state_nxt = M_STOPWATCH;
        M_STOPWATCH: state_nxt = M_TIMER;
        default:     state_nxt = M_WATCH;
      endcase
    end else begin
      fwd_en = 1'b1;
`ifdef WATCH_AUTO_RETURN_EN
      if (state != M_WATCH && !(|btn_pedge[2:0])) begin
        idle_nxt = idle_cnt;
        if (sec_tick) begin
          if (idle_cnt == IDLE_LAST) begin
            state_nxt = M_WATCH;
            idle_nxt  = 8'd0;
          end else begin
            idle_nxt = idle_cnt + 8'd1;
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state         <= M_WATCH;
      saved         <= M_WATCH;
      tick_cnt      <= 32'd0;
      alarm_cnt     <= 8'd0;
      sec_tick      <= 1'b0;
      watch_btn     <= 3'd0;
      stopwatch_btn <= 3'd0;
      timer_btn     <= 3'd0;
      disp_value    <= 16'd0;
`ifdef WATCH_AUTO_RETURN_EN
      idle_cnt      <= 8'd0;
`endif
    end else begin
      state         <= state_nxt;
      saved         <= saved_nxt;
      alarm_cnt     <= alarm_cnt_nxt;
      tick_cnt      <= (tick_cnt == TICK_LAST) ? 32'd0 : tick_cnt + 32'd1;
      sec_tick      <= (tick_cnt == TICK_LAST);
      watch_btn     <= (fwd_en && state == M_WATCH)     ? btn_pedge[2:0] : 3'd0;
      stopwatch_btn <= (fwd_en && state == M_STOPWATCH) ? btn_pedge[2:0] : 3'd0;
      timer_btn     <= (fwd_en && state == M_TIMER)     ? btn_pedge[2:0] : 3'd0;
      case (state)
        M_WATCH:     disp_value <= watch_bcd;
        M_STOPWATCH: disp_value <= stopwatch_bcd;
        default:     disp_value <= timer_bcd;
      endcase
`ifdef WATCH_AUTO_RETURN_EN
      idle_cnt      <= idle_nxt;
`endif
    end
  end

  assign mode     = state;
  assign mode_led = 4'b0001 << state;
  assign alarm    = (state == M_ALARM);

endmodule
